// File: rtl/reg_bank_responder.sv
// Register-bank responder: DEPTH-entry storage with per-entry valid bits,
// registered one-cycle reads with miss flag, and a sequential CLEAR sweep.
module reg_bank_responder #(
   parameter int unsigned DATA_W = 5,
   parameter int unsigned ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] WA,
   input  logic [DATA_W-1:0] DataIn,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] RA,
   input  logic              clr_en,
   output logic [DATA_W-1:0] RdData,
   output logic              rd_valid,
   output logic              rd_miss,
   output logic [ADDR_W:0]   Count,
   output logic              busy
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   typedef enum logic {
      IDLE,
      CLEAR
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              rd_miss_q, rd_miss_d;
   logic              busy_q, busy_d;
   logic              wr_hit;

   // A read of the address being written in the same cycle sees the new data.
   assign wr_hit = wr_en && (WA == RA);

   always_comb begin
      state_d    = state_q;
      clr_ptr_d  = clr_ptr_q;
      mem_d      = mem_q;
      valid_d    = valid_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      rd_miss_d  = rd_miss_q;
      rd_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (clr_en) begin
               state_d   = CLEAR;
               clr_ptr_d = '0;
            end else begin
               if (rd_en) begin
                  rd_valid_d = 1'b1;
                  if (wr_hit) begin
                     rd_data_d = DataIn;
                     rd_miss_d = 1'b0;
                  end else if (valid_q[RA]) begin
                     rd_data_d = mem_q[RA];
                     rd_miss_d = 1'b0;
                  end else begin
                     rd_data_d = '0;
                     rd_miss_d = 1'b1;
                  end
               end
               if (wr_en) begin
                  mem_d[WA]   = DataIn;
                  valid_d[WA] = 1'b1;
                  if (!valid_q[WA]) begin
                     count_d = count_q + 1'b1;
                  end
               end
            end
         end
         CLEAR: begin
            mem_d[clr_ptr_q]   = '0;
            valid_d[clr_ptr_q] = 1'b0;
            if (valid_q[clr_ptr_q]) begin
               count_d = count_q - 1'b1;
            end
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == LAST_IDX) begin
               state_d = IDLE;
            end
         end
      endcase

      busy_d = (state_d == CLEAR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         clr_ptr_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         valid_q    <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_miss_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_ptr_q  <= clr_ptr_d;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         valid_q    <= valid_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         rd_miss_q  <= rd_miss_d;
         busy_q     <= busy_d;
      end
   end

   assign RdData   = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign rd_miss  = rd_miss_q;
   assign Count    = count_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_reg_bank_responder.sv
// Bench for reg_bank_responder: directed scenarios plus random traffic,
// checked against a behavioural model of the register bank.
module tb_reg_bank_responder;

   localparam int DEPTH = 4;

   logic       clk;
   logic       rst;
   logic       wr_en;
   logic [1:0] WA;
   logic [4:0] DataIn;
   logic       rd_en;
   logic [1:0] RA;
   logic       clr_en;
   logic [4:0] RdData;
   logic       rd_valid;
   logic       rd_miss;
   logic [2:0] Count;
   logic       busy;

   int vectors;
   int miscompares;

   // Behavioural model state
   logic [4:0] m_mem [DEPTH];
   bit         m_valid [DEPTH];
   bit         m_clearing;
   int         m_ptr;
   logic [4:0] m_rd_data;
   bit         m_rd_valid;
   bit         m_rd_miss;

   reg_bank_responder #(.DATA_W(5), .ADDR_W(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .WA       (WA),
      .DataIn   (DataIn),
      .rd_en    (rd_en),
      .RA       (RA),
      .clr_en   (clr_en),
      .RdData   (RdData),
      .rd_valid (rd_valid),
      .rd_miss  (rd_miss),
      .Count    (Count),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int model_count();
      int n = 0;
      for (int i = 0; i < DEPTH; i++) n += m_valid[i] ? 1 : 0;
      return n;
   endfunction

   // Apply the bank's rules for one rising edge using the currently driven inputs.
   task automatic model_edge();
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_valid[i] = 0;
         end
         m_clearing = 0; m_ptr = 0;
         m_rd_data = '0; m_rd_valid = 0; m_rd_miss = 0;
      end else if (m_clearing) begin
         m_mem[m_ptr] = '0;
         m_valid[m_ptr] = 0;
         m_ptr++;
         if (m_ptr == DEPTH) begin
            m_clearing = 0;
            m_ptr = 0;
         end
         m_rd_valid = 0;
      end else if (clr_en) begin
         m_clearing = 1;
         m_ptr = 0;
         m_rd_valid = 0;
      end else begin
         m_rd_valid = rd_en;
         if (rd_en) begin
            if (wr_en && WA == RA) begin
               m_rd_data = DataIn; m_rd_miss = 0;
            end else begin
               m_rd_data = m_valid[RA] ? m_mem[RA] : 5'd0;
               m_rd_miss = !m_valid[RA];
            end
         end
         if (wr_en) begin
            m_mem[WA] = DataIn;
            m_valid[WA] = 1;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("RdData", {3'b0, RdData}, {3'b0, m_rd_data});
      chk("rd_valid", {7'b0, rd_valid}, {7'b0, m_rd_valid});
      chk("rd_miss", {7'b0, rd_miss}, {7'b0, m_rd_miss});
      chk("Count", {5'b0, Count}, 8'(model_count()));
      chk("busy", {7'b0, busy}, {7'b0, m_clearing});
   endtask

   task automatic cyc(input bit r, input bit w, input logic [1:0] wa, input logic [4:0] d,
                      input bit rd, input logic [1:0] ra, input bit c);
      rst = r; wr_en = w; WA = wa; DataIn = d; rd_en = rd; RA = ra; clr_en = c;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   int nbusy;
   logic [31:0] rv;

   initial begin
      vectors = 0; miscompares = 0;
      rst = 1; wr_en = 0; WA = 0; DataIn = 0; rd_en = 0; RA = 0; clr_en = 0;
      m_clearing = 0; m_ptr = 0; m_rd_data = '0; m_rd_valid = 0; m_rd_miss = 0;
      for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_valid[i] = 0; end

      // Reset state
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("rst_count", {5'b0, Count}, 8'd0);
      chk("rst_busy", {7'b0, busy}, 8'd0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      // Read of unwritten entry misses
      cyc(0, 0, 0, 0, 1, 2, 0);
      chk("miss_valid", {7'b0, rd_valid}, 8'd1);
      chk("miss_flag", {7'b0, rd_miss}, 8'd1);
      chk("miss_data", {3'b0, RdData}, 8'd0);

      // Writes and overwrite
      cyc(0, 1, 0, 5'h11, 0, 0, 0);
      chk("cnt_w1", {5'b0, Count}, 8'd1);
      cyc(0, 1, 3, 5'h0A, 0, 0, 0);
      chk("cnt_w2", {5'b0, Count}, 8'd2);
      cyc(0, 1, 0, 5'h1F, 0, 0, 0);
      chk("cnt_ovr", {5'b0, Count}, 8'd2);
      cyc(0, 0, 0, 0, 1, 0, 0);
      chk("rd0_data", {3'b0, RdData}, 8'h1F);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("rd_hold", {3'b0, RdData}, 8'h1F);

      // Same-address write and read: write-first
      cyc(0, 1, 1, 5'h07, 1, 1, 0);
      chk("wf_data", {3'b0, RdData}, 8'h07);
      chk("wf_miss", {7'b0, rd_miss}, 8'd0);
      chk("wf_count", {5'b0, Count}, 8'd3);

      // Fill, then CLEAR with a write in the same cycle
      cyc(0, 1, 2, 5'h15, 0, 0, 0);
      chk("full", {5'b0, Count}, 8'd4);
      cyc(0, 1, 2, 5'h03, 1, 2, 1);
      chk("clr_drop_rv", {7'b0, rd_valid}, 8'd0);
      nbusy = busy ? 1 : 0;
      for (int i = 0; i < 6; i++) begin
         cyc(0, 1, 2'(i), 5'h1E, 1, 2'(i), 0);
         if (busy) nbusy++;
         if (i < 3) chk("sweep_cnt", {5'b0, Count}, 8'(3 - i));
      end
      chk("busy_len", 8'(nbusy), 8'd4);
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("post_clr_cnt", {5'b0, Count}, 8'd0);
      for (int i = 0; i < DEPTH; i++) begin
         cyc(0, 0, 0, 0, 1, 2'(i), 0);
         chk("post_clr_miss", {7'b0, rd_miss}, 8'd1);
      end

      // Reset aborts CLEAR on its second cycle
      cyc(0, 1, 1, 5'h09, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("abort_busy", {7'b0, busy}, 8'd0);
      chk("abort_cnt", {5'b0, Count}, 8'd0);
      cyc(0, 1, 3, 5'h12, 0, 0, 0);
      chk("abort_wr", {5'b0, Count}, 8'd1);

      // Back-to-back reads
      for (int i = 0; i < DEPTH; i++) cyc(0, 1, 2'(i), 5'(8 + 3 * i), 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) begin
         cyc(0, 0, 0, 0, 1, 2'(i), 0);
         chk("b2b_data", {3'b0, RdData}, 8'(8 + 3 * i));
         chk("b2b_valid", {7'b0, rd_valid}, 8'd1);
      end

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         rv = $urandom;
         cyc(rv[5:0] == 6'd0, rv[6], rv[8:7], rv[13:9], rv[14], rv[16:15], rv[20:17] == 4'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/reg_bank_responder.md
Name: reg_bank_responder

Overview:
Storage-side responder for the 2-bit address / 5-bit data register-bank interface driven by the operation-sequencing state machine. It accepts write-address/data and read-address commands, holds a DEPTH-entry register bank with per-entry valid bits, and returns registered read data with a miss flag. A multi-cycle sequential CLEAR sweep is built in, and its busy indication tells the sequencer when commands are accepted.

Parameters:
DATA_W, 5, width of each stored word and of DataIn/RdData
ADDR_W, 2, width of WA/RA; DEPTH = 2**ADDR_W (4 by default)

Ports:
clk  input  1  rising-edge clock, the only clock
rst  input  1  reset, synchronous, active-high
wr_en  input  1  write command strobe, sampled each rising edge
WA  input  ADDR_W  write address
DataIn  input  DATA_W  write data
rd_en  input  1  read command strobe
RA  input  ADDR_W  read address
clr_en  input  1  start CLEAR sweep
RdData  output  DATA_W  read data, registered
rd_valid  output  1  one-cycle pulse: RdData/rd_miss updated this cycle
rd_miss  output  1  read targeted an entry never written since reset/clear
Count  output  ADDR_W+1  number of valid entries, 0..DEPTH
busy  output  1  CLEAR sweep in progress; commands ignored

Behaviour:
- Reset (rst=1 at an edge): mem[*]=0, valid[*]=0, Count=0, RdData=0, rd_valid=0, rd_miss=0, busy=0, state=IDLE, clr_ptr=0. Reset during CLEAR aborts it; reset wins over every command.
- States: IDLE, CLEAR. IDLE→CLEAR on clr_en=1. CLEAR→IDLE after the edge that clears entry DEPTH-1. clr_en in CLEAR is ignored.
- busy is a registered signal, equal to (state==CLEAR); it goes high on the edge after clr_en is sampled and stays high for exactly DEPTH cycles.
- Command priority in IDLE: clr_en > {wr_en, rd_en}. wr_en/rd_en in the same cycle as clr_en are dropped (no rd_valid pulse). All commands are ignored while busy=1.
- Write (IDLE, wr_en=1): mem[WA]<=DataIn; valid[WA]<=1. Count+1 only if valid[WA] was 0. Overwriting a valid entry leaves Count unchanged.
- Read (IDLE, rd_en=1): one-cycle latency. At the next edge RdData<=mem[RA], rd_miss<=~valid[RA], rd_valid<=1. On a miss, RdData<=0.
- Simultaneous write and read in the same cycle:
  - Same address: write-first. RdData returns the new DataIn, rd_miss=0.
  - Different addresses: both proceed independently.
- If rd_valid=0, RdData holds its last value and rd_miss holds its last value.
- CLEAR sweep: each cycle in CLEAR, mem[clr_ptr]<=0 and valid[clr_ptr]<=0. Count decrements by 1 only if that entry was valid. clr_ptr increments, wraps to 0 at DEPTH-1, and the state returns to IDLE. After the sweep, Count=0.
- Count never wraps; its maximum is DEPTH (needs ADDR_W+1 bits).
- Out-of-range addresses are impossible by width; no bounds logic is required.

Test Plan:
- Reset, then check outputs → RdData=0, rd_valid=0, rd_miss=0, Count=0, busy=0; then read RA=2 → next cycle rd_valid=1, rd_miss=1, RdData=0.
- Write 5'h11→WA0, 5'h0A→WA3, then 5'h1F→WA0 → Count goes 1,2,2; read RA=0 → RdData=5'h1F, rd_miss=0, one cycle after rd_en.
- Same cycle: wr_en WA=1 DataIn=5'h07 and rd_en RA=1 → next cycle RdData=5'h07, rd_miss=0, Count+1.
- Fill all 4 entries (Count=4), pulse clr_en together with wr_en → write dropped; busy=1 for exactly 4 cycles; Count steps 3,2,1,0; wr_en during busy has no effect; every read after the sweep misses.
- Assert clr_en, then rst=1 on the second CLEAR cycle → next edge: busy=0, Count=0, all entries invalid; a write next cycle is accepted with Count=1.
- Back-to-back reads RA=0,1,2,3 on consecutive cycles after writes → four consecutive rd_valid pulses with matching data in order.
